cdc_fifo_src_arb: RTL and testbench

Round-robin, packet-aware arbiter that shares the single source port of a gray-pointer CDC FIFO among `N_REQ` requesters in the source clock domain. It picks one requester, keeps the FIFO-side payload stable until the FIFO accepts it, and holds the grant until that requester's packet ends. It also emits the winner's index alongside the data, so the destination side can demultiplex. Fully synchronous to the FIFO's source clock; the FIFO itself is unchanged.

---
 rtl/cdc_fifo_src_arb_if.sv | 34 +++
 rtl/cdc_fifo_src_arb.sv | 124 ++++++++++++
 tb/tb_cdc_fifo_src_arb.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_fifo_src_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : cdc_fifo_src_arb_if
// Brief    : Requester-side and FIFO-source-side signal bundle for
//            cdc_fifo_src_arb.
// Revision : 1.0  initial release
// ============================================================================
interface cdc_fifo_src_arb_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ-1:0]       req_last_i;
  logic [N_REQ*WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic                   fifo_valid_o;
  logic [WIDTH+IDX_W-1:0] fifo_data_o;
  logic                   fifo_ready_i;
  logic                   busy_o;
  logic [IDX_W-1:0]       owner_o;

  modport slave (
    input  req_valid_i, req_last_i, req_data_i, fifo_ready_i,
    output req_ready_o, fifo_valid_o, fifo_data_o, busy_o, owner_o
  );

  modport master (
    output req_valid_i, req_last_i, req_data_i, fifo_ready_i,
    input  req_ready_o, fifo_valid_o, fifo_data_o, busy_o, owner_o
  );
endinterface
`default_nettype wire

// File: rtl/cdc_fifo_src_arb.sv
`default_nettype none
// ============================================================================
// Module   : cdc_fifo_src_arb
// Brief    : Packet-aware round-robin arbiter sharing one CDC FIFO source
//            port; tags each beat with the winner index.
//            Optional: CDC_FIFO_SRC_ARB_BURST_LIMIT_EN releases the grant
//            after MAX_BURST beats even mid-packet.
// Revision : 1.0  initial release
// ============================================================================
module cdc_fifo_src_arb #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  cdc_fifo_src_arb_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_REQ - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt, w_cnt_inc;
  logic [IDX_W-1:0] w_win_idx, w_sel;
  logic [IDX_W:0]   w_scan;
  logic             w_any_valid, w_hs, w_last, w_release, w_burst_done;

  // Explicit wrap so non-power-of-two N_REQ never yields an unused index.
  function automatic logic [IDX_W-1:0] f_inc(input logic [IDX_W-1:0] idx);
    return (idx == c_last_idx) ? '0 : idx + IDX_W'(1);
  endfunction

  always_comb begin : p_pick
    w_win_idx = '0;
    w_scan    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_scan > {1'b0, c_last_idx}) w_scan = w_scan - (IDX_W+1)'(N_REQ);
      if (bus.req_valid_i[w_scan[IDX_W-1:0]]) w_win_idx = w_scan[IDX_W-1:0];
    end
  end

  always_comb begin : p_mux
    w_any_valid      = |bus.req_valid_i;
    w_sel            = (r_state == LOCKED) ? r_owner : w_win_idx;
    bus.fifo_valid_o = (r_state == LOCKED) ? bus.req_valid_i[r_owner] : w_any_valid;
    bus.fifo_data_o  = {w_sel, bus.req_data_i[int'(w_sel)*WIDTH +: WIDTH]};
    w_last           = bus.req_last_i[w_sel];
    bus.req_ready_o  = '0;
    if ((r_state == LOCKED) || w_any_valid) bus.req_ready_o[w_sel] = bus.fifo_ready_i;
    w_hs             = bus.fifo_valid_o & bus.fifo_ready_i;
    bus.busy_o       = (r_state == LOCKED);
    bus.owner_o      = w_sel;
  end

  assign w_cnt_inc = (r_state == LOCKED) ? r_beat_cnt + CNT_W'(1) : CNT_W'(1);

`ifdef CDC_FIFO_SRC_ARB_BURST_LIMIT_EN
  localparam logic [CNT_W-1:0] c_max_burst = CNT_W'(MAX_BURST);
  assign w_burst_done = (w_cnt_inc == c_max_burst);
`else
  assign w_burst_done = 1'b0;
`endif

  always_comb begin : p_next
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_beat_cnt_nxt = r_beat_cnt;
    w_release      = w_hs && (w_last || w_burst_done);
    case (r_state)
      IDLE: begin
        if (w_release) begin
          w_rr_ptr_nxt = f_inc(w_sel);
        end else if (bus.fifo_valid_o) begin
          // A stalled offer locks too, freezing the presented beat.
          w_state_nxt    = LOCKED;
          w_owner_nxt    = w_sel;
          w_beat_cnt_nxt = w_hs ? w_cnt_inc : '0;
        end
      end
      LOCKED: begin
        if (w_release) begin
          w_state_nxt    = IDLE;
          w_rr_ptr_nxt   = f_inc(w_sel);
          w_beat_cnt_nxt = '0;
        end else if (w_hs) begin
          w_beat_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_proto
    a_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (bus.req_valid_i[gi] && !bus.req_ready_o[gi]) |=>
        (bus.req_valid_i[gi] && $stable(bus.req_last_i[gi]) &&
         $stable(bus.req_data_i[gi*WIDTH +: WIDTH])));
  end
endmodule
`default_nettype wire

// File: tb/tb_cdc_fifo_src_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_fifo_src_arb
// Brief    : Scoreboard bench for cdc_fifo_src_arb: directed scenarios plus
//            randomized traffic against a packet-level arbitration model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cdc_fifo_src_arb;
  localparam int N_REQ     = 4;
  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 8;
  localparam int IDX_W     = $clog2(N_REQ);
`ifdef CDC_FIFO_SRC_ARB_BURST_LIMIT_EN
  localparam int MAX_LEN   = 12;
  localparam bit BURST_ON  = 1'b1;
`else
  localparam int MAX_LEN   = 6;
  localparam bit BURST_ON  = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cdc_fifo_src_arb_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  cdc_fifo_src_arb #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t            pend[N_REQ][$];   // beats not yet accepted, per requester
  logic [WIDTH-1:0] exp_q[N_REQ][$];  // scoreboard: offered beats awaiting acceptance
  int               grant_log[$];
  int               grant_cyc[$];
  int               exp_log[$];
  logic [N_REQ-1:0] hs_seen = '0;
  bit               rdy_force = 1'b1;
  bit               rdy_val   = 1'b1;
  int               p_valid   = 100;
  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc   = 0;

  // Packet-level arbitration model: who is committed to the port, where the
  // round-robin search starts, beats granted in the current commitment.
  bit               m_commit = 1'b0;
  int               m_owner  = 0;
  int               m_rr     = 0;
  int               m_beats  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_pkt(input int r, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.last = (k == len - 1);
      b.data = $urandom;
      pend[r].push_back(b);
    end
  endtask

  function automatic bit all_idle();
    bit idle = (bus.req_valid_i == '0);
    for (int r = 0; r < N_REQ; r++) if (pend[r].size() != 0) idle = 1'b0;
    return idle;
  endfunction

  task automatic wait_drain(input string tag);
    int n = 0;
    while (n < 2000 && !all_idle()) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_%s: traffic still pending after %0d cycles, required 0 pending", tag, n);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic check_log(input string tag, input bit b2b);
    check({tag, "_grant_count"}, grant_log.size(), exp_log.size());
    for (int j = 0; j < exp_log.size() && j < grant_log.size(); j++) begin
      check({tag, "_grant_idx"}, grant_log[j], exp_log[j]);
      if (b2b && j > 0) check({tag, "_b2b"}, grant_cyc[j] - grant_cyc[j-1], 1);
    end
    grant_log.delete();
    grant_cyc.delete();
  endtask

  // Driver: one beat per requester, held until its ready is observed.
  initial begin : drv
    bus.req_valid_i  = '0;
    bus.req_last_i   = '0;
    bus.req_data_i   = '0;
    bus.fifo_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        for (int r = 0; r < N_REQ; r++) begin
          if (bus.req_valid_i[r] && hs_seen[r]) begin
            void'(pend[r].pop_front());
            bus.req_valid_i[r] = 1'b0;
          end
          if (!bus.req_valid_i[r] && pend[r].size() > 0 && ($urandom_range(99) < p_valid)) begin
            bus.req_valid_i[r]               = 1'b1;
            bus.req_last_i[r]                = pend[r][0].last;
            bus.req_data_i[r*WIDTH +: WIDTH] = pend[r][0].data;
            exp_q[r].push_back(pend[r][0].data);
          end
        end
        bus.fifo_ready_i = rdy_force ? rdy_val : ($urandom_range(99) < 70);
      end
    end
  end

  // Monitor: predicts the port from the model and scores each accepted beat.
  initial begin : mon
    int   sel;
    logic exp_v;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_commit = 1'b0; m_owner = 0; m_rr = 0; m_beats = 0;
        hs_seen  = '0;
      end else begin
        hs_seen = bus.req_valid_i & bus.req_ready_o;
        sel   = 0;
        exp_v = 1'b0;
        if (m_commit) begin
          sel   = m_owner;
          exp_v = bus.req_valid_i[sel];
        end else begin
          for (int k = 0; k < N_REQ; k++) begin
            if (!exp_v && bus.req_valid_i[(m_rr + k) % N_REQ]) begin
              sel   = (m_rr + k) % N_REQ;
              exp_v = 1'b1;
            end
          end
        end
        check("fifo_valid", bus.fifo_valid_o, exp_v);
        check("busy", bus.busy_o, m_commit);
        check("ready_onehot0", $onehot0(bus.req_ready_o), 1);
        if (exp_v || m_commit) begin
          check("owner", bus.owner_o, sel);
          check("req_ready", bus.req_ready_o, bus.fifo_ready_i ? (64'd1 << sel) : 64'd0);
        end
        if (exp_v && bus.fifo_ready_i) begin
          check("index", bus.fifo_data_o[WIDTH +: IDX_W], sel);
          if (exp_q[sel].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL payload: beat accepted from requester %0d, required none outstanding", sel);
          end else begin
            check("payload", bus.fifo_data_o[WIDTH-1:0], exp_q[sel].pop_front());
          end
          grant_log.push_back(sel);
          grant_cyc.push_back(cyc);
          m_beats++;
          if (bus.req_last_i[sel] || (BURST_ON && m_beats == MAX_BURST)) begin
            m_commit = 1'b0;
            m_rr     = (sel + 1) % N_REQ;
            m_beats  = 0;
          end else begin
            m_commit = 1'b1;
            m_owner  = sel;
          end
        end else if (exp_v) begin
          m_commit = 1'b1;
          m_owner  = sel;
        end
      end
    end
  end

  initial begin : stim
    logic [WIDTH+IDX_W-1:0] d0;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy_o, 0);
    check("rst_owner", bus.owner_o, 0);
    check("rst_fifo_valid", bus.fifo_valid_o, 0);
    check("rst_req_ready", bus.req_ready_o, 0);
    #1 rst_n = 1'b1;

    // Two single beats: 0 then 2 on consecutive cycles.
    add_pkt(0, 1); add_pkt(2, 1);
    wait_drain("t1");
    exp_log = '{0, 2};
    check_log("t1", 1'b1);

    // All four valid with the pointer at 3.
    add_pkt(3, 1); add_pkt(0, 1); add_pkt(1, 1); add_pkt(2, 1);
    wait_drain("t4");
    exp_log = '{3, 0, 1, 2};
    check_log("t4", 1'b1);

    add_pkt(0, 1);
    wait_drain("pre_t2");
    exp_log = '{0};
    check_log("pre_t2", 1'b0);

    // Three-beat packet from 1 holds the port against 3.
    add_pkt(1, 3); add_pkt(3, 1);
    wait_drain("t2");
    exp_log = '{1, 1, 1, 3};
    check_log("t2", 1'b1);

    // FIFO back-pressure while 0 is presenting and 1 joins.
    rdy_val = 1'b0;
    add_pkt(0, 1);
    @(posedge clk);
    #2;
    add_pkt(1, 1);
    d0 = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) d0 = bus.fifo_data_o;
      else begin
        check("t3_data_stable", bus.fifo_data_o, d0);
        check("t3_busy", bus.busy_o, 1);
      end
      check("t3_no_ready", bus.req_ready_o, 0);
    end
    rdy_val = 1'b1;
    wait_drain("t3");
    exp_log = '{0, 1};
    check_log("t3", 1'b0);

`ifdef CDC_FIFO_SRC_ARB_BURST_LIMIT_EN
    add_pkt(2, 12); add_pkt(0, 1);
    wait_drain("burst");
    exp_log = '{2, 2, 2, 2, 2, 2, 2, 2, 0, 2, 2, 2, 2};
    check_log("burst", 1'b1);
`endif

    // Asynchronous reset in the middle of a locked packet.
    add_pkt(1, 3);
    n = 0;
    while (grant_log.size() < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_first_beat_seen", (grant_log.size() >= 1), 1);
    @(negedge clk);
    check("t6_locked_busy", bus.busy_o, 1);
    check("t6_locked_owner", bus.owner_o, 1);
    #2;
    rst_n = 1'b0;
    bus.req_valid_i = '0;
    for (int r = 0; r < N_REQ; r++) begin
      pend[r].delete();
      exp_q[r].delete();
    end
    #1;
    check("t6_async_busy", bus.busy_o, 0);
    check("t6_async_owner", bus.owner_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    grant_log.delete();
    grant_cyc.delete();
    add_pkt(3, 1); add_pkt(1, 1);
    wait_drain("t6");
    exp_log = '{1, 3};
    check_log("t6", 1'b0);

    // Randomized traffic and FIFO back-pressure.
    rdy_force = 1'b0;
    p_valid   = 60;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      for (int r = 0; r < N_REQ; r++)
        if (pend[r].size() == 0 && $urandom_range(3) == 0) add_pkt(r, $urandom_range(1, MAX_LEN));
    end
    rdy_force = 1'b1;
    rdy_val   = 1'b1;
    p_valid   = 100;
    wait_drain("random");
    for (int r = 0; r < N_REQ; r++) check("scoreboard_empty", exp_q[r].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
